// File: rtl/ext_intf_pkg.sv
// Shared encodings for the host external link: receiver FSM states, phase tags,
// CNTR word bit positions and the timeout fill pattern.
package ext_intf_pkg;

   typedef enum logic [3:0] {
      ST_RX_CNTR  = 4'h0,
      ST_RX_ADDR0 = 4'h1,
      ST_RX_ADDR1 = 4'h2,
      ST_RX_WDAT0 = 4'h3,
      ST_RX_WDAT1 = 4'h4,
      ST_BUS_REQ  = 4'h5,
      ST_BUS_DATA = 4'h6,
      ST_RESP0    = 4'h8,
      ST_RESP1    = 4'h9,
      ST_RESP2    = 4'hA,
      ST_RESP3    = 4'hB
   } rx_state_e;

   localparam logic [2:0] PH_CNTR = 3'b100;
   localparam logic [2:0] PH_ADDR = 3'b010;
   localparam logic [2:0] PH_WDAT = 3'b001;

   localparam int CNTR_WT_BIT = 4;
   localparam int CNTR_BE_LSB = 0;
   localparam int CNTR_BE_W   = 4;

   localparam logic [31:0] RDT_TIMEOUT = 32'hDEAD_DEAD;

   // Phase tag a receive state expects to see on the incoming word.
   function automatic logic [2:0] exp_phase(rx_state_e s);
      case (s)
         ST_RX_CNTR:               return PH_CNTR;
         ST_RX_ADDR0, ST_RX_ADDR1: return PH_ADDR;
         default:                  return PH_WDAT;
      endcase
   endfunction

endpackage

// File: rtl/ext_rx_resp_ser.sv
// Read-response serializer: holds the 32-bit read result and presents it as four
// bytes LSB-first, with the fault flag only on the last byte.
module ext_rx_resp_ser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        load_fault,
   input  logic        active,
   input  logic [1:0]  idx,
   input  logic        resp_ack,
   output logic        resp_valid,
   output logic [7:0]  resp_data,
   output logic        resp_flag
);

   logic [31:0] rdt_q, rdt_d;
   logic        fault_q, fault_d;

   always_comb begin
      rdt_d   = rdt_q;
      fault_d = fault_q;
      if (load) begin
         rdt_d   = load_data;
         fault_d = load_fault;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         rdt_q   <= rdt_d;
         fault_q <= fault_d;
      end
   end

   // A byte is pushed whenever the FIFO has room; the FSM advances idx on the same strobe.
   assign resp_valid = active & resp_ack;
   assign resp_data  = active ? rdt_q[{idx, 3'b000} +: 8] : 8'h00;
   assign resp_flag  = active & (idx == 2'd3) & fault_q;

endmodule

// File: rtl/ext_intf_receiver.sv
// Far-end receiver of the host external link: rebuilds single accesses from the
// 16-bit word stream, runs them on the local master port and returns read bytes.
// Optional phase-tag framing check: define EXT_RX_PHASE_CHECK_EN.
module ext_intf_receiver
   import ext_intf_pkg::*;
#(
   parameter int TIMEOUT_W = 8,
   parameter int CNTR_W    = 5
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        Ext_TRANS_VALID,
   input  logic [2:0]  Ext_TRANS_PHASE,
   input  logic [15:0] Ext_TRANS_DATA,
   output logic        Ext_TRANS_ACK,
   output logic        Ext_RESP_VALID,
   output logic        Ext_RESP_RESP,
   output logic [7:0]  Ext_RESP_DATA,
   input  logic        Ext_RESP_ACK,
   output logic        M_REQ,
   output logic        M_WT,
   output logic [3:0]  M_BE,
   output logic [31:0] M_ADDR,
   output logic [31:0] M_WDT,
   input  logic        M_nWAIT,
   input  logic [31:0] M_RDT,
   input  logic        M_FAULT,
   output logic        RX_ERR
);

   // Fires on the (2**TIMEOUT_W-1)th consecutive stall cycle.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = ~(TIMEOUT_W'(1));

   rx_state_e              state_q, state_d;
   logic                   wt_q, wt_d;
   logic [3:0]             be_q, be_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdt_q, wdt_d;
   logic [TIMEOUT_W-1:0]   to_cnt_q, to_cnt_d;
   logic                   err_q, err_d;
   logic                   req_q, req_d;

   logic                   rx_st, pop, to_expire;
   logic                   phase_bad, phase_restart;
   logic                   ld, ld_fault, resp_active;
   logic [31:0]            ld_data;
   logic [CNTR_W-1:0]      cntr_word;

   assign cntr_word = Ext_TRANS_DATA[CNTR_W-1:0];
   assign rx_st     = state_q inside {ST_RX_CNTR, ST_RX_ADDR0, ST_RX_ADDR1,
                                      ST_RX_WDAT0, ST_RX_WDAT1};
   assign pop       = Ext_TRANS_VALID & rx_st;
   assign to_expire = (to_cnt_q == TO_LAST);

`ifdef EXT_RX_PHASE_CHECK_EN
   assign phase_bad     = pop && (Ext_TRANS_PHASE != exp_phase(state_q));
   assign phase_restart = phase_bad && (Ext_TRANS_PHASE == PH_CNTR);
`else
   logic unused_phase;
   assign unused_phase  = ^Ext_TRANS_PHASE;
   assign phase_bad     = 1'b0;
   assign phase_restart = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      wt_d     = wt_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdt_d    = wdt_q;
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
      ld       = 1'b0;
      ld_data  = M_RDT;
      ld_fault = M_FAULT;
      if (phase_bad) begin
         // Misframed word is consumed; a CNTR-tagged one starts a fresh transfer.
         err_d   = 1'b1;
         state_d = ST_RX_CNTR;
         if (phase_restart) begin
            wt_d    = cntr_word[CNTR_WT_BIT];
            be_d    = cntr_word[CNTR_BE_LSB +: CNTR_BE_W];
            state_d = ST_RX_ADDR0;
         end
      end else begin
         case (state_q)
            ST_RX_CNTR: if (pop) begin
               wt_d    = cntr_word[CNTR_WT_BIT];
               be_d    = cntr_word[CNTR_BE_LSB +: CNTR_BE_W];
               state_d = ST_RX_ADDR0;
            end
            ST_RX_ADDR0: if (pop) begin
               addr_d[15:0] = Ext_TRANS_DATA;
               state_d      = ST_RX_ADDR1;
            end
            ST_RX_ADDR1: if (pop) begin
               addr_d[31:16] = Ext_TRANS_DATA;
               state_d       = wt_q ? ST_RX_WDAT0 : ST_BUS_REQ;
            end
            ST_RX_WDAT0: if (pop) begin
               wdt_d[15:0] = Ext_TRANS_DATA;
               state_d     = ST_RX_WDAT1;
            end
            ST_RX_WDAT1: if (pop) begin
               wdt_d[31:16] = Ext_TRANS_DATA;
               state_d      = ST_BUS_REQ;
            end
            ST_BUS_REQ: begin
               if (M_nWAIT) begin
                  to_cnt_d = '0;
                  state_d  = wt_q ? ST_RX_CNTR : ST_BUS_DATA;
               end else if (to_expire) begin
                  to_cnt_d = '0;
                  err_d    = 1'b1;
                  if (wt_q) begin
                     state_d = ST_RX_CNTR;
                  end else begin
                     ld       = 1'b1;
                     ld_data  = RDT_TIMEOUT;
                     ld_fault = 1'b1;
                     state_d  = ST_RESP0;
                  end
               end else begin
                  to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
               end
            end
            ST_BUS_DATA: begin
               if (M_nWAIT) begin
                  to_cnt_d = '0;
                  ld       = 1'b1;
                  state_d  = ST_RESP0;
               end else if (to_expire) begin
                  to_cnt_d = '0;
                  err_d    = 1'b1;
                  ld       = 1'b1;
                  ld_data  = RDT_TIMEOUT;
                  ld_fault = 1'b1;
                  state_d  = ST_RESP0;
               end else begin
                  to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
               end
            end
            ST_RESP0: if (Ext_RESP_VALID) state_d = ST_RESP1;
            ST_RESP1: if (Ext_RESP_VALID) state_d = ST_RESP2;
            ST_RESP2: if (Ext_RESP_VALID) state_d = ST_RESP3;
            ST_RESP3: if (Ext_RESP_VALID) state_d = ST_RX_CNTR;
            default:  state_d = ST_RX_CNTR;
         endcase
      end
      req_d = (state_d == ST_BUS_REQ);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= ST_RX_CNTR;
         wt_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdt_q    <= '0;
         to_cnt_q <= '0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wt_q     <= wt_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdt_q    <= wdt_d;
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
         req_q    <= req_d;
      end
   end

   assign resp_active = state_q inside {ST_RESP0, ST_RESP1, ST_RESP2, ST_RESP3};

   ext_rx_resp_ser u_resp_ser (
      .clk        (CLK),
      .rst_n      (nRST),
      .load       (ld),
      .load_data  (ld_data),
      .load_fault (ld_fault),
      .active     (resp_active),
      .idx        (state_q[1:0]),
      .resp_ack   (Ext_RESP_ACK),
      .resp_valid (Ext_RESP_VALID),
      .resp_data  (Ext_RESP_DATA),
      .resp_flag  (Ext_RESP_RESP)
   );

   // The pop strobe is combinational from VALID, so hold it low while in reset.
   assign Ext_TRANS_ACK = pop & nRST;
   assign M_REQ         = req_q;
   assign M_WT          = wt_q;
   assign M_BE          = be_q;
   assign M_ADDR        = addr_q;
   assign M_WDT         = wdt_q;
   assign RX_ERR        = err_q;

endmodule

// File: tb/tb_ext_intf_receiver.sv
// Scoreboard bench for ext_intf_receiver: directed frames push expected bus
// accesses and response bytes; monitors pop and compare as the DUT presents them.
module tb_ext_intf_receiver;
   import ext_intf_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        Ext_TRANS_VALID = 1'b0;
   logic [2:0]  Ext_TRANS_PHASE = 3'b000;
   logic [15:0] Ext_TRANS_DATA = 16'h0000;
   logic        Ext_TRANS_ACK;
   logic        Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_ACK;
   logic [7:0]  Ext_RESP_DATA;
   logic        M_REQ, M_WT, M_nWAIT, M_FAULT, RX_ERR;
   logic [3:0]  M_BE;
   logic [31:0] M_ADDR, M_WDT, M_RDT;

   ext_intf_receiver dut (
      .CLK(CLK), .nRST(nRST),
      .Ext_TRANS_VALID(Ext_TRANS_VALID), .Ext_TRANS_PHASE(Ext_TRANS_PHASE),
      .Ext_TRANS_DATA(Ext_TRANS_DATA), .Ext_TRANS_ACK(Ext_TRANS_ACK),
      .Ext_RESP_VALID(Ext_RESP_VALID), .Ext_RESP_RESP(Ext_RESP_RESP),
      .Ext_RESP_DATA(Ext_RESP_DATA), .Ext_RESP_ACK(Ext_RESP_ACK),
      .M_REQ(M_REQ), .M_WT(M_WT), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_WDT(M_WDT),
      .M_nWAIT(M_nWAIT), .M_RDT(M_RDT), .M_FAULT(M_FAULT), .RX_ERR(RX_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic wt; logic [3:0] be; logic [31:0] addr; logic [31:0] wdt; } bus_t;
   typedef struct { logic [7:0] d; logic f; } resp_t;
   bus_t  exp_bus[$];
   resp_t exp_resp[$];

   int checks = 0;
   int errors = 0;
   int req_hi = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // Slave model: cfg stalls per phase, or hang forever for the timeout case.
   int          cfg_req_stall = 0, cfg_dat_stall = 0;
   bit          hang = 0, ack_alt = 0, gap_mode = 0;
   int          wait_left = 0;
   bit          data_ph = 0, tog = 0;
   logic [31:0] cfg_rdt = 32'h0;
   logic        cfg_fault = 1'b0;

   assign M_nWAIT      = !hang && (wait_left == 0);
   assign M_RDT        = cfg_rdt;
   assign M_FAULT      = cfg_fault;
   assign Ext_RESP_ACK = ack_alt ? tog : 1'b1;

   always @(posedge CLK) begin
      tog <= ~tog;
      if (!nRST) begin
         data_ph   <= 1'b0;
         wait_left <= 0;
      end else if (data_ph) begin
         if (M_nWAIT) begin
            data_ph   <= 1'b0;
            wait_left <= cfg_req_stall;
         end else if (wait_left > 0) wait_left <= wait_left - 1;
      end else if (M_REQ) begin
         if (M_nWAIT) begin
            data_ph   <= !M_WT;
            wait_left <= M_WT ? cfg_req_stall : cfg_dat_stall;
         end else if (wait_left > 0) wait_left <= wait_left - 1;
      end else begin
         wait_left <= cfg_req_stall;
      end
   end

   // Monitors: bus acceptance and response bytes.
   always @(negedge CLK) begin
      if (M_REQ) req_hi <= req_hi + 1;
      if (nRST && M_REQ && M_nWAIT) begin
         if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexp: got access addr 0x%0h wt %0d, required none", M_ADDR, M_WT);
         end else begin
            bus_t e;
            e = exp_bus.pop_front();
            chk("bus_wt", M_WT, e.wt);
            chk("bus_be", M_BE, e.be);
            chk("bus_addr", M_ADDR, e.addr);
            if (e.wt) chk("bus_wdt", M_WDT, e.wdt);
         end
      end
      if (nRST && Ext_RESP_VALID) begin
         if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexp: got byte 0x%0h, required no byte", Ext_RESP_DATA);
         end else begin
            resp_t r;
            r = exp_resp.pop_front();
            chk("resp_data", Ext_RESP_DATA, r.d);
            chk("resp_flag", Ext_RESP_RESP, r.f);
         end
      end
   end

   task automatic send_word(input logic [15:0] d, input logic [2:0] ph);
      int  n = 0;
      bit  got = 0;
      Ext_TRANS_VALID = 1'b1; Ext_TRANS_DATA = d; Ext_TRANS_PHASE = ph;
      while (!got && n < 2000) begin
         @(negedge CLK); got = Ext_TRANS_ACK;
         @(posedge CLK); #1; n++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL trans_ack: word 0x%0h never popped, required a pop", d);
      end
      Ext_TRANS_VALID = 1'b0;
      if (gap_mode) begin @(posedge CLK); #1; end
   endtask

   task automatic send_read(input logic [3:0] be, input logic [31:0] addr);
      send_word({12'h000, be}, PH_CNTR);
      send_word(addr[15:0], PH_ADDR);
      send_word(addr[31:16], PH_ADDR);
   endtask

   task automatic exp_bytes(input logic [7:0] b0, b1, b2, b3, input logic f);
      exp_resp.push_back('{d: b0, f: 1'b0});
      exp_resp.push_back('{d: b1, f: 1'b0});
      exp_resp.push_back('{d: b2, f: 1'b0});
      exp_resp.push_back('{d: b3, f: f});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_bus.size() != 0 || exp_resp.size() != 0) && n < budget) begin
         @(posedge CLK); #1; n++;
      end
      checks++;
      if (exp_bus.size() != 0 || exp_resp.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d bus and %0d resp items left after %0d cycles, required 0",
                  exp_bus.size(), exp_resp.size(), n);
         exp_bus.delete(); exp_resp.delete();
      end
      repeat (6) @(posedge CLK);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      // Reset state, with a word already waiting.
      #2 Ext_TRANS_VALID = 1'b1;
      #1;
      chk("rst_ack", Ext_TRANS_ACK, 0);
      chk("rst_rvalid", Ext_RESP_VALID, 0);
      chk("rst_rresp", Ext_RESP_RESP, 0);
      chk("rst_rdata", Ext_RESP_DATA, 0);
      chk("rst_req", M_REQ, 0);
      chk("rst_wt", M_WT, 0);
      chk("rst_be", M_BE, 0);
      chk("rst_addr", M_ADDR, 0);
      chk("rst_wdt", M_WDT, 0);
      chk("rst_err", RX_ERR, 0);
      Ext_TRANS_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) nRST = 1'b1;
      @(posedge CLK); #1;

      // Plain read.
      cfg_rdt = 32'hA1B2C3D4;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h12345678, wdt: 32'h0});
      exp_bytes(8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b0);
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_ADDR); send_word(16'h1234, PH_ADDR);
      drain(200);

      // Plain write: no response byte may appear.
      exp_bus.push_back('{wt: 1'b1, be: 4'h3, addr: 32'h80000004, wdt: 32'hCAFEBEEF});
      send_word(16'h0013, PH_CNTR); send_word(16'h0004, PH_ADDR); send_word(16'h8000, PH_ADDR);
      send_word(16'hBEEF, PH_WDAT); send_word(16'hCAFE, PH_WDAT);
      drain(200);

      // Same read with VALID toggling.
      gap_mode = 1;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h12345678, wdt: 32'h0});
      exp_bytes(8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b0);
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_ADDR); send_word(16'h1234, PH_ADDR);
      drain(200);
      gap_mode = 0;

      // Bus stalls of 3 cycles in both phases.
      cfg_req_stall = 3; cfg_dat_stall = 3; cfg_rdt = 32'h0BADF00D;
      snap = req_hi;
      exp_bus.push_back('{wt: 1'b0, be: 4'h5, addr: 32'h00000100, wdt: 32'h0});
      exp_bytes(8'h0D, 8'hF0, 8'hAD, 8'h0B, 1'b0);
      send_read(4'h5, 32'h00000100);
      drain(200);
      chk("stall_req_cycles", req_hi - snap, 4);
      exp_bus.push_back('{wt: 1'b1, be: 4'hC, addr: 32'h00000020, wdt: 32'h12345678});
      send_word(16'h001C, PH_CNTR); send_word(16'h0020, PH_ADDR); send_word(16'h0000, PH_ADDR);
      send_word(16'h5678, PH_WDAT); send_word(16'h1234, PH_WDAT);
      drain(200);
      cfg_req_stall = 0; cfg_dat_stall = 0;

      // Response ACK low on alternate cycles.
      ack_alt = 1; cfg_rdt = 32'h01020304;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h00000040, wdt: 32'h0});
      exp_bytes(8'h04, 8'h03, 8'h02, 8'h01, 1'b0);
      send_read(4'hF, 32'h00000040);
      drain(200);
      ack_alt = 0;

      // Slave fault.
      cfg_fault = 1'b1; cfg_rdt = 32'h00000000;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h00000044, wdt: 32'h0});
      exp_bytes(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      send_read(4'hF, 32'h00000044);
      drain(200);
      cfg_fault = 1'b0;
      chk("err_before_to", RX_ERR, 0);

      // Timeout: 255 request cycles, then DEADDEAD with fault.
      hang = 1; snap = req_hi;
      exp_bytes(8'hAD, 8'hDE, 8'hAD, 8'hDE, 1'b1);
      send_read(4'hF, 32'h00000048);
      drain(2000);
      chk("to_req_cycles", req_hi - snap, 255);
      chk("to_err", RX_ERR, 1);
      hang = 0;

      // Next read completes normally.
      cfg_rdt = 32'h13579BDF;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h0000004C, wdt: 32'h0});
      exp_bytes(8'hDF, 8'h9B, 8'h57, 8'h13, 1'b0);
      send_read(4'hF, 32'h0000004C);
      drain(200);

      // Asynchronous reset mid-frame after ADDR0.
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_ADDR);
      Ext_TRANS_VALID = 1'b1; Ext_TRANS_DATA = 16'h1234; Ext_TRANS_PHASE = PH_ADDR;
      #2 nRST = 1'b0;
      #1;
      chk("mrst_ack", Ext_TRANS_ACK, 0);
      chk("mrst_addr", M_ADDR, 0);
      chk("mrst_be", M_BE, 0);
      chk("mrst_err", RX_ERR, 0);
      chk("mrst_req", M_REQ, 0);
      Ext_TRANS_VALID = 1'b0;
      @(negedge CLK) nRST = 1'b1;
      @(posedge CLK); #1;
      cfg_rdt = 32'hA1B2C3D4;
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h12345678, wdt: 32'h0});
      exp_bytes(8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b0);
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_ADDR); send_word(16'h1234, PH_ADDR);
      drain(200);

`ifdef EXT_RX_PHASE_CHECK_EN
      // Misframed ADDR0 is dropped and flagged.
      chk("ph_err_before", RX_ERR, 0);
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_WDAT);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK); chk("ph_no_req", M_REQ, 0);
      end
      @(posedge CLK); #1;
      chk("ph_err", RX_ERR, 1);
      exp_bus.push_back('{wt: 1'b0, be: 4'hF, addr: 32'h12345678, wdt: 32'h0});
      exp_bytes(8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b0);
      send_word(16'h000F, PH_CNTR); send_word(16'h5678, PH_ADDR); send_word(16'h1234, PH_ADDR);
      drain(200);
      // CNTR-tagged word in the ADDR0 slot restarts the transfer as a write.
      exp_bus.push_back('{wt: 1'b1, be: 4'h3, addr: 32'h80000004, wdt: 32'hCAFEBEEF});
      send_word(16'h000F, PH_CNTR); send_word(16'h0013, PH_CNTR);
      send_word(16'h0004, PH_ADDR); send_word(16'h8000, PH_ADDR);
      send_word(16'hBEEF, PH_WDAT); send_word(16'hCAFE, PH_WDAT);
      drain(200);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
